page_router: RTL
================

PAGE_ROUTER -- requirements
Module: page_router

Interface
REQ-001 Parameters SHALL be: NUM_PAGES, default 4, number of page slots; IN_W, default 32, user-input bundle width; OUT_W, default 64, page-output bundle width; DIV, default SYS_FREQ/PROG_FREQ, clk cycles per tick; RST_TICKS, default 2, page-reset length in ticks; INIT_PAGE, default 0, page after reset.
REQ-002 Derived width SHALL be PW = max(1, clog2(NUM_PAGES)).
REQ-003 Ports SHALL be:
- clk  in  1  system clock.
- sys_rst  in  1  reset; asynchronous, active-high.
- tick  out  1  one-clk program-clock enable.
- user_in  in  IN_W  edged user input.
- page_out  in  NUM_PAGES x OUT_W  output bundle of each page.
- page_req  in  NUM_PAGES x PW  next page requested by each page.
- page_in  out  NUM_PAGES x IN_W  input routed to each page.
- page_rst  out  NUM_PAGES  per-page reset.
- prog_out  out  OUT_W  bundle of the current page.
- cur_page  out  PW  active page.
- busy  out  1  switch in progress.
- bad_req  out  1  sticky illegal-request flag.
- switch_cnt  out  16  accepted transitions, saturating.

Function
REQ-004 The tick counter SHALL run 0..DIV-1 on clk, wrap to 0, and assert tick only while the count equals DIV-1, giving exactly one pulse per DIV cycles.
REQ-005 DIV=1 SHALL hold tick high continuously.
REQ-006 The FSM SHALL have two states, RUN and SWITCH, and SHALL change state, cur_page or counters only on clk edges where tick=1.
REQ-007 In RUN on a tick, r=page_req[cur_page] SHALL be evaluated as follows:
- r==cur_page: no action.
- r<NUM_PAGES and r!=cur_page: cur_page<=r, enter SWITCH, load reset counter with RST_TICKS, increment switch_cnt, saturating at 16'hFFFF.
- r>=NUM_PAGES: set bad_req, stay in RUN.
REQ-008 In SWITCH, each tick SHALL decrement the reset counter, and the FSM SHALL return to RUN on the tick where the counter reaches 0, so page_rst lasts exactly RST_TICKS ticks.
REQ-009 In SWITCH, page_req SHALL be ignored.
REQ-010 page_rst[i] SHALL be combinational: sys_rst OR (state==SWITCH AND i==cur_page).
REQ-011 page_in[i] SHALL equal user_in when state==RUN and i==cur_page, and all-zero otherwise, including during SWITCH.
REQ-012 prog_out SHALL equal page_out[cur_page] combinationally in both states, with no added latency.
REQ-013 busy SHALL equal (state==SWITCH).
REQ-014 bad_req SHALL clear only on sys_rst.
REQ-015 RST_TICKS=0 SHALL be treated as 1.

Reset
REQ-016 On sys_rst, the block SHALL set:
- tick counter to 0;
- cur_page to INIT_PAGE;
- state to SWITCH, reset counter to RST_TICKS;
- switch_cnt and bad_req to 0.
The initial page therefore gets a full reset pulse after release.
REQ-017 sys_rst asserted mid-SWITCH SHALL abort the switch and reinitialise as in REQ-016; all page_rst bits SHALL be high while sys_rst is high.

Structure
REQ-018 SYS_FREQ, PROG_FREQ and the page-ID enumeration SHALL live in the shared header package.
REQ-019 The RUN/SWITCH state typedef SHALL be local to the module.
REQ-020 The tick counter SHALL be a separate sub-module, tick_gen, parametrised by DIV, with ports clk, sys_rst and tick.
REQ-021 Routing SHALL use generate loops over NUM_PAGES, not a fixed case statement.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- DIV=4, release reset -> tick high on clk cycles 3, 7, 11, ...
- Release reset, RST_TICKS=2 -> page_rst[0]=1 and busy=1 for 2 ticks, then RUN with cur_page=0 and page_in[0]=user_in.
- In RUN with cur_page=0, page_req[0]=2 -> cur_page=2 after next tick, page_rst[2] high for 2 ticks, page_in all zero meanwhile, switch_cnt=1.
- NUM_PAGES=3, page_req[cur]=3 -> bad_req=1, cur_page unchanged, switch_cnt unchanged.
- sys_rst pulsed mid-SWITCH to page 1 -> cur_page=INIT_PAGE, all page_rst high during reset, switch_cnt=0.
- Force 65537 transitions -> switch_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/page_router_pkg.sv
// Shared header for the page router: clock plan, page identifiers and width helpers.
package page_router_pkg;

  localparam int SYS_FREQ  = 48_000_000;
  localparam int PROG_FREQ = 12_000_000;

  typedef enum logic [1:0] {
    PAGE_0 = 2'd0,
    PAGE_1 = 2'd1,
    PAGE_2 = 2'd2,
    PAGE_3 = 2'd3
  } page_id_e;

  // A one-page configuration still needs a one-bit page index.
  function automatic int pw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/page_router_tick_gen.sv
// Program-clock enable: one clk-wide pulse every DIV system clocks.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic sys_rst,
  output logic tick
);

  localparam int              D    = (DIV < 1) ? 1 : DIV;
  localparam int              CW   = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0]   LAST = CW'(D - 1);

  logic [CW-1:0] cnt_r;

  // Free-running divider counter, wraps at DIV-1.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // With DIV=1 the counter never leaves zero, so tick stays high.
  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/page_router.sv
// Routes user input to the active page, mirrors its output bundle, and
// sequences page switches with a reset pulse measured in program ticks.
module page_router
  import page_router_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 64,
  parameter int DIV       = SYS_FREQ / PROG_FREQ,
  parameter int RST_TICKS = 2,
  parameter int INIT_PAGE = int'(PAGE_0),
  localparam int PW       = pw_of(NUM_PAGES)
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  output logic                       tick,
  input  logic [IN_W-1:0]            user_in,
  input  logic [NUM_PAGES*OUT_W-1:0] page_out,
  input  logic [NUM_PAGES*PW-1:0]    page_req,
  output logic [NUM_PAGES*IN_W-1:0]  page_in,
  output logic [NUM_PAGES-1:0]       page_rst,
  output logic [OUT_W-1:0]           prog_out,
  output logic [PW-1:0]              cur_page,
  output logic                       busy,
  output logic                       bad_req,
  output logic [15:0]                switch_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    SWITCH = 1'b1
  } state_t;

  // A zero-length reset would never let the new page see a reset edge.
  localparam int              RT     = (RST_TICKS < 1) ? 1 : RST_TICKS;
  localparam int              RCW    = $clog2(RT + 1);
  localparam logic [RCW-1:0]  RT_W   = RCW'(RT);
  localparam logic [RCW-1:0]  ONE_W  = RCW'(1);
  localparam logic [PW-1:0]   INIT_W = PW'(INIT_PAGE);
  localparam logic [PW:0]     NP_W   = (PW + 1)'(NUM_PAGES);

  state_t           state_r;
  logic [PW-1:0]    cur_page_r;
  logic [RCW-1:0]   rst_cnt_r;
  logic [15:0]      switch_cnt_r;
  logic             bad_req_r;
  logic             tick_s;
  logic             busy_s;
  logic             req_legal_s;
  logic [PW-1:0]    cur_req_s;
  logic [OUT_W-1:0] prog_s;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .sys_rst(sys_rst),
    .tick   (tick_s)
  );

  // Select the active page's request and output bundle by one-hot masking.
  always_comb begin
    cur_req_s = {PW{1'b0}};
    prog_s    = {OUT_W{1'b0}};
    for (int i = 0; i < NUM_PAGES; i++) begin
      cur_req_s = cur_req_s | ((cur_page_r == PW'(i)) ? page_req[i*PW +: PW] : {PW{1'b0}});
      prog_s    = prog_s | ((cur_page_r == PW'(i)) ? page_out[i*OUT_W +: OUT_W] : {OUT_W{1'b0}});
    end
  end

  assign req_legal_s = ({1'b0, cur_req_s} < NP_W);
  assign busy_s      = (state_r == SWITCH);

  // Page sequencer; everything advances only on program ticks.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r      <= SWITCH;
      cur_page_r   <= INIT_W;
      rst_cnt_r    <= RT_W;
      switch_cnt_r <= 16'd0;
      bad_req_r    <= 1'b0;
    end else if (tick_s) begin
      case (state_r)
        RUN: begin
          if (!req_legal_s) begin
            bad_req_r <= 1'b1;
          end else if (cur_req_s != cur_page_r) begin
            cur_page_r <= cur_req_s;
            state_r    <= SWITCH;
            rst_cnt_r  <= RT_W;
            if (switch_cnt_r != 16'hFFFF) begin
              switch_cnt_r <= switch_cnt_r + 16'd1;
            end
          end
        end
        SWITCH: begin
          rst_cnt_r <= rst_cnt_r - ONE_W;
          if (rst_cnt_r == ONE_W) begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PAGES; i++) begin : g_route
    localparam logic [PW-1:0] IDX = PW'(i);
    assign page_rst[i]             = sys_rst | (busy_s & (cur_page_r == IDX));
    assign page_in[i*IN_W +: IN_W] = (!busy_s && (cur_page_r == IDX)) ? user_in : {IN_W{1'b0}};
  end

  assign tick       = tick_s;
  assign prog_out   = prog_s;
  assign cur_page   = cur_page_r;
  assign busy       = busy_s;
  assign bad_req    = bad_req_r;
  assign switch_cnt = switch_cnt_r;

endmodule
